// File: rtl/gate_pkg.sv
// Shared types and constants for the gate sweep controller.
// Holds the FSM state encoding and the sweep length.
package gate_pkg;

    localparam int NUM_VEC = 8;
    localparam int VEC_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/gate3_ref.sv
// Golden model of the 3-input gate unit under test.
// Produces the expected AND and NAND outputs for a vector.
module gate3_ref (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic exp_and,
    output logic exp_nand
);

    assign exp_and  = a & b & c;
    assign exp_nand = ~(a & b & c);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Sweeps all eight input vectors through a 3-input gate unit
// and scores its AND/NAND outputs against a golden model.
module gate_sweep_ctrl
    import gate_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       x_in,
    input  logic       y_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_vec
);

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);
    localparam logic [2:0] LAST_VEC = 3'(NUM_VEC - 1);
    localparam logic [3:0] ERR_MAX  = 4'(NUM_VEC);

    state_e     state;
    logic [2:0] idx;
    logic [3:0] cnt;
    logic       exp_and;
    logic       exp_nand;
    logic       mism;
    logic [3:0] err_inc;

    // idx is cleared whenever the block returns to IDLE,
    // so the gate inputs read 0 while idle.
    assign {a, b, c} = idx;

    gate3_ref u_ref (
        .a        (a),
        .b        (b),
        .c        (c),
        .exp_and  (exp_and),
        .exp_nand (exp_nand)
    );

    assign mism = (x_in != exp_and) | (y_in != exp_nand);

    assign err_inc = (err_count == ERR_MAX) ?
                     err_count : err_count + 4'd1;

    // Sweep FSM with counters and scoreboard; abort beats CHECK.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= 3'd0;
            cnt       <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 4'd0;
            fail_vec  <= 8'd0;
        end else begin
            done <= 1'b0;
            if (state != ST_IDLE && abort) begin
                state <= ST_IDLE;
                idx   <= 3'd0;
                cnt   <= 4'd0;
                busy  <= 1'b0;
                pass  <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            idx       <= 3'd0;
                            err_count <= 4'd0;
                            fail_vec  <= 8'd0;
                            pass      <= 1'b0;
                            cnt       <= CNT_INIT;
                            busy      <= 1'b1;
                            state     <= ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (cnt == 4'd0) begin
                            state <= ST_CHECK;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    ST_CHECK: begin
                        if (mism) begin
                            fail_vec[idx] <= 1'b1;
                            err_count     <= err_inc;
                        end
                        if (idx == LAST_VEC) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            pass  <= !mism && (err_count == 4'd0);
                        end else begin
                            idx   <= idx + 3'd1;
                            cnt   <= CNT_INIT;
                            state <= ST_SETTLE;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        idx   <= 3'd0;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        idx   <= 3'd0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
